nubus_mem_arbiter: RTL and testbench
====================================

Name: nubus_mem_arbiter

Overview:
- Two-requester arbiter that shares one simple memory port (valid/wstrb/addr/wdata/rdata/ready) between the NuBus slave path (port A) and the local CPU path (port B).
- Captures the winning request into registers and drives the memory port until ready; returns registered read data and a one-cycle ready pulse to the owner.
- Provides round-robin or fixed priority, plus a bus-hang timeout that completes the transfer with an error flag.

Parameters:
- ROUND_ROBIN, 1, 1 = alternate on simultaneous requests; 0 = port A always wins.
- TIMEOUT, 255, max cycles in BUSY without m_ready before forced error completion; 0 = timeout disabled.
- TO_W, 8, width of the timeout counter; must satisfy TIMEOUT < 2**TO_W.

Ports:
- mem_clk  in  1  clock, all logic on rising edge
- mem_resetn  in  1  asynchronous active-low reset
- a_valid  in  1  port A request, held until a_ready
- a_wstrb  in  4  port A byte write strobes; 0 = read
- a_addr  in  32  port A byte address
- a_wdata  in  32  port A write data
- a_rdata  out  32  port A read data, valid with a_ready
- a_ready  out  1  port A completion pulse
- a_error  out  1  port A timeout flag, valid with a_ready
- b_valid, b_wstrb, b_addr, b_wdata, b_rdata, b_ready, b_error  same as port A, for port B
- m_valid  out  1  memory request
- m_wstrb  out  4  memory strobes
- m_addr  out  32  memory address
- m_wdata  out  32  memory write data
- m_rdata  in  32  memory read data
- m_ready  in  1  memory acknowledge
- owner  out  2  00 none, 01 A, 10 B

Behaviour:
- Reset (async, mem_resetn=0):
  - state=IDLE, owner=00, last_grant=B (so A wins the first tie).
  - All outputs 0: m_valid, m_wstrb, m_addr, m_wdata, x_ready, x_error, x_rdata.
  - Reset mid-transfer abandons the transfer; no ready pulse is issued.
- IDLE:
  - No valid: stay in IDLE.
  - Any valid: pick the winner and go to BUSY.
  - Tie with ROUND_ROBIN=1: the winner is the port other than last_grant. With ROUND_ROBIN=0: A wins.
  - On the grant edge, register the winner's wstrb/addr/wdata into m_*, set m_valid=1, owner=winner, last_grant=winner, clear the timeout counter.
  - m_ready is ignored in IDLE.
- BUSY:
  - m_* registers are held stable. The requester may change its inputs; it has no effect.
  - m_ready=1: capture m_rdata into the owner's x_rdata (write cycles capture too; the value is don't-care), set x_error=0, drop m_valid, go to DONE.
  - Timeout: if TIMEOUT!=0 and the counter reaches TIMEOUT with m_ready=0, then x_rdata=32'hFFFF_FFFF, x_error=1, drop m_valid, go to DONE. The counter saturates and does not wrap.
  - m_ready and timeout in the same cycle: m_ready wins, no error.
- DONE (exactly one cycle):
  - Owner's x_ready=1 (x_error as captured). Non-owner's ready stays 0.
  - Next state is IDLE; owner returns to 00; x_ready and x_error clear.
  - x_rdata holds until that port's next completion.
- Requester dropping valid during BUSY: the memory transfer still completes and the ready pulse is still issued. The requester must ignore it.
- Requester holding valid through DONE: treated as a new request in IDLE (back-to-back).
- Latency:
  - Grant: 1 edge after valid sampled in IDLE.
  - Completion: x_ready is high the cycle after m_ready is sampled.
  - Minimum turnaround is 3 cycles per transfer (IDLE, BUSY, DONE) with single-cycle memory ready.
- Fairness: with both ports continuously requesting and ROUND_ROBIN=1, grants strictly alternate.

Decomposition:
- Package nubus_arb_pkg:
  - state enum {IDLE, BUSY, DONE}
  - owner encodings OWN_NONE/OWN_A/OWN_B
  - ERR_RDATA = 32'hFFFF_FFFF
  - default TIMEOUT constant
- Sub-module nubus_arb_pick: combinational winner select from a_valid, b_valid, last_grant and ROUND_ROBIN. Isolated so it can be reused for a later 3-port variant.

Test Plan:
- Single read A: after reset, A reads 0x10, memory returns 0xDEADBEEF after 2 wait cycles -> m_valid for 3 cycles, a_rdata=0xDEADBEEF with a_ready pulse 1 cycle, a_error=0, b_ready never high.
- Byte write B: wstrb=4'b0100, addr 0x20, wdata 0x00AB0000 -> m_wstrb=0100, m_addr=0x20 and m_wdata held stable throughout BUSY; b_ready pulse; owner=10 during BUSY.
- Simultaneous requests, ROUND_ROBIN=1, both held for 4 transfers -> grant order A,B,A,B. With ROUND_ROBIN=0 -> A,A,A,A while A is held.
- Timeout: TIMEOUT=8, m_ready tied 0 -> m_valid drops after 8 BUSY cycles; a_ready=1, a_error=1, a_rdata=0xFFFFFFFF; next request proceeds normally.
- m_ready coincident with timeout cycle -> data captured, a_error=0.
- Reset asserted mid-BUSY -> m_valid and owner clear immediately (async), no ready pulse; the first post-reset tie goes to A.

Source files
------------

// File: rtl/nubus_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nubus_arb_pkg
//  Description : Shared types and constants for the NuBus / CPU memory
//                port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package nubus_arb_pkg;

  // Arbiter sequencing: grant, wait for memory, one-cycle completion pulse
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  // Current owner of the memory port, as presented on the owner output
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_A    = 2'b01,
    OWN_B    = 2'b10
  } owner_e;

  // Read data returned when a transfer is forced to complete by the timeout
  localparam logic [31:0] ERR_RDATA = 32'hFFFF_FFFF;

  // Default bus-hang limit in BUSY cycles
  localparam int DEFAULT_TIMEOUT = 255;

endpackage : nubus_arb_pkg
`default_nettype wire

// File: rtl/nubus_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : nubus_arb_pick
//  Description : Combinational winner select between two requesters.
//                Round-robin uses the last grant to break ties; fixed
//                priority always favours port A.
//  Revision    : 1.0 - initial release
// ============================================================================
module nubus_arb_pick
  import nubus_arb_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic   a_valid_i,
  input  logic   b_valid_i,
  input  logic   last_grant_b_i,
  output owner_e winner_o
);

  logic tie_pick_b;

  // Tie-break policy: alternate away from the last grant, or always pick A
  if (ROUND_ROBIN != 0) begin : g_rr
    assign tie_pick_b = ~last_grant_b_i;
  end else begin : g_fixed
    assign tie_pick_b = 1'b0;
  end

  // Winner select; OWN_NONE when nobody is requesting
  always_comb begin
    winner_o = OWN_NONE;
    if (a_valid_i && b_valid_i) begin
      winner_o = tie_pick_b ? OWN_B : OWN_A;
    end else if (a_valid_i) begin
      winner_o = OWN_A;
    end else if (b_valid_i) begin
      winner_o = OWN_B;
    end
  end

endmodule : nubus_arb_pick
`default_nettype wire

// File: rtl/nubus_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : nubus_mem_arbiter
//  Description : Shares one memory port between the NuBus slave path (A)
//                and the local CPU path (B). The winning request is
//                registered onto the memory port and held until m_ready or
//                a bus-hang timeout, then a one-cycle ready pulse returns
//                registered read data to the owner.
//  Revision    : 1.0 - initial release
// ============================================================================
module nubus_mem_arbiter
  import nubus_arb_pkg::*;
#(
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT,
  parameter int TO_W        = 8
) (
  input  logic        mem_clk,
  input  logic        mem_resetn,
  input  logic        a_valid,
  input  logic [3:0]  a_wstrb,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic [31:0] a_rdata,
  output logic        a_ready,
  output logic        a_error,
  input  logic        b_valid,
  input  logic [3:0]  b_wstrb,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic [31:0] b_rdata,
  output logic        b_ready,
  output logic        b_error,
  output logic        m_valid,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic [1:0]  owner
);

  // Counter value seen during the last BUSY cycle allowed before timeout
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  arb_state_e      state_q,   state_d;
  owner_e          owner_q,   owner_d;
  logic            last_b_q,  last_b_d;
  logic            m_valid_q, m_valid_d;
  logic [3:0]      m_wstrb_q, m_wstrb_d;
  logic [31:0]     m_addr_q,  m_addr_d;
  logic [31:0]     m_wdata_q, m_wdata_d;
  logic [TO_W-1:0] cnt_q,     cnt_d;
  logic [31:0]     a_rdata_q, a_rdata_d;
  logic [31:0]     b_rdata_q, b_rdata_d;
  logic            a_ready_q, a_ready_d;
  logic            b_ready_q, b_ready_d;
  logic            a_error_q, a_error_d;
  logic            b_error_q, b_error_d;

  owner_e          winner;
  logic            timeout_hit;
  logic [31:0]     done_rdata;

  nubus_arb_pick #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_pick (
    .a_valid_i      (a_valid),
    .b_valid_i      (b_valid),
    .last_grant_b_i (last_b_q),
    .winner_o       (winner)
  );

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);
  // m_ready beats the timeout when both land in the same cycle
  assign done_rdata  = m_ready ? m_rdata : ERR_RDATA;

  // State register; reset abandons any transfer without a ready pulse
  always_ff @(posedge mem_clk or negedge mem_resetn) begin
    if (!mem_resetn) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_NONE;
      last_b_q  <= 1'b1;
      m_valid_q <= 1'b0;
      m_wstrb_q <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      cnt_q     <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      a_ready_q <= 1'b0;
      b_ready_q <= 1'b0;
      a_error_q <= 1'b0;
      b_error_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_b_q  <= last_b_d;
      m_valid_q <= m_valid_d;
      m_wstrb_q <= m_wstrb_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      cnt_q     <= cnt_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      a_ready_q <= a_ready_d;
      b_ready_q <= b_ready_d;
      a_error_q <= a_error_d;
      b_error_q <= b_error_d;
    end
  end

  // Next-state: grant in IDLE, wait for memory or timeout in BUSY, pulse in DONE
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_b_d  = last_b_q;
    m_valid_d = m_valid_q;
    m_wstrb_d = m_wstrb_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    cnt_d     = cnt_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    a_ready_d = 1'b0;
    b_ready_d = 1'b0;
    a_error_d = 1'b0;
    b_error_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (winner != OWN_NONE) begin
          state_d   = ST_BUSY;
          owner_d   = winner;
          last_b_d  = (winner == OWN_B);
          m_valid_d = 1'b1;
          cnt_d     = '0;
          if (winner == OWN_A) begin
            m_wstrb_d = a_wstrb;
            m_addr_d  = a_addr;
            m_wdata_d = a_wdata;
          end else begin
            m_wstrb_d = b_wstrb;
            m_addr_d  = b_addr;
            m_wdata_d = b_wdata;
          end
        end
      end
      ST_BUSY: begin
        if (m_ready || timeout_hit) begin
          state_d   = ST_DONE;
          m_valid_d = 1'b0;
          if (owner_q == OWN_A) begin
            a_rdata_d = done_rdata;
            a_ready_d = 1'b1;
            a_error_d = ~m_ready;
          end else begin
            b_rdata_d = done_rdata;
            b_ready_d = 1'b1;
            b_error_d = ~m_ready;
          end
        end else if (cnt_q != {TO_W{1'b1}}) begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d   = ST_IDLE;
        owner_d   = OWN_NONE;
        m_valid_d = 1'b0;
      end
    endcase
  end

  assign m_valid = m_valid_q;
  assign m_wstrb = m_wstrb_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign owner   = owner_q;
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
  assign a_ready = a_ready_q;
  assign b_ready = b_ready_q;
  assign a_error = a_error_q;
  assign b_error = b_error_q;

endmodule : nubus_mem_arbiter
`default_nettype wire

// File: tb/tb_nubus_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nubus_mem_arbiter
//  Description : Self-checking bench for nubus_mem_arbiter. A round-robin
//                instance takes directed and random transactions checked
//                against a transaction-level model; a fixed-priority
//                instance checks that A keeps winning while held.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nubus_mem_arbiter;

  localparam int TO_TB = 8;

  logic        clk = 1'b0;
  logic        mem_resetn;
  logic        a_valid, b_valid, m_ready;
  logic [3:0]  a_wstrb, b_wstrb, m_wstrb;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata, m_rdata;
  logic [31:0] a_rdata, b_rdata, m_addr, m_wdata;
  logic        a_ready, a_error, b_ready, b_error, m_valid;
  logic [1:0]  owner;

  logic        f_a_valid, f_b_valid, f_m_ready;
  logic [31:0] f_a_addr, f_a_rdata, f_b_rdata, f_m_addr, f_m_wdata;
  logic [3:0]  f_m_wstrb;
  logic        f_a_ready, f_a_error, f_b_ready, f_b_error, f_m_valid;
  logic [1:0]  f_owner;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: who was granted last, and each port's held rdata
  bit          mdl_last_b;
  logic [31:0] mdl_rd_a, mdl_rd_b;

  always #5 clk = ~clk;

  nubus_mem_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(TO_TB), .TO_W(8)) u_dut (
    .mem_clk(clk), .mem_resetn(mem_resetn),
    .a_valid(a_valid), .a_wstrb(a_wstrb), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_ready(a_ready), .a_error(a_error),
    .b_valid(b_valid), .b_wstrb(b_wstrb), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_ready(b_ready), .b_error(b_error),
    .m_valid(m_valid), .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .owner(owner)
  );

  nubus_mem_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(TO_TB), .TO_W(8)) u_dut_fixed (
    .mem_clk(clk), .mem_resetn(mem_resetn),
    .a_valid(f_a_valid), .a_wstrb(4'h0), .a_addr(f_a_addr), .a_wdata(32'h0),
    .a_rdata(f_a_rdata), .a_ready(f_a_ready), .a_error(f_a_error),
    .b_valid(f_b_valid), .b_wstrb(4'hF), .b_addr(32'hB0B0_0000), .b_wdata(32'h1),
    .b_rdata(f_b_rdata), .b_ready(f_b_ready), .b_error(f_b_error),
    .m_valid(f_m_valid), .m_wstrb(f_m_wstrb), .m_addr(f_m_addr), .m_wdata(f_m_wdata),
    .m_rdata(32'h1234_5678), .m_ready(f_m_ready), .owner(f_owner)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction, entered at a negedge with the arbiter idle. w is the
  // number of memory wait cycles before m_ready (beyond TO_TB-1 => timeout).
  task automatic run_txn(input bit va, input bit vb,
                         input logic [3:0] sa, input logic [31:0] aa, input logic [31:0] da,
                         input logic [3:0] sb, input logic [31:0] ab, input logic [31:0] db,
                         input int w, input logic [31:0] mdata);
    bit          win_b;
    bit          fin;
    bit          exp_err;
    logic [3:0]  e_s;
    logic [31:0] e_a, e_d, e_rd;
    chk("idle_owner", owner, 2'b00);
    chk("idle_mvalid", m_valid, 1'b0);
    chk("idle_ready", {a_ready, b_ready}, 2'b00);
    a_valid = va; a_wstrb = sa; a_addr = aa; a_wdata = da;
    b_valid = vb; b_wstrb = sb; b_addr = ab; b_wdata = db;
    win_b = (va && vb) ? !mdl_last_b : vb;
    mdl_last_b = win_b;
    e_s = win_b ? sb : sa;
    e_a = win_b ? ab : aa;
    e_d = win_b ? db : da;
    @(negedge clk);
    chk("grant_owner", owner, win_b ? 2'b10 : 2'b01);
    chk("grant_wstrb", m_wstrb, e_s);
    for (int k = 0; k < 64; k++) begin
      chk("busy_mvalid", m_valid, 1'b1);
      chk("busy_addr", m_addr, e_a);
      chk("busy_wdata", m_wdata, e_d);
      chk("busy_wstrb", m_wstrb, e_s);
      chk("busy_ready", {a_ready, b_ready}, 2'b00);
      m_ready = (k == w);
      m_rdata = (k == w) ? mdata : $urandom;
      fin = (k == w) || (k == TO_TB - 1);
      // the owner may scribble on or drop its request while waiting
      if (win_b) begin
        b_addr = $urandom; b_wdata = $urandom; b_wstrb = 4'($urandom);
        if ($urandom_range(0, 3) == 0) b_valid = 1'b0;
      end else begin
        a_addr = $urandom; a_wdata = $urandom; a_wstrb = 4'($urandom);
        if ($urandom_range(0, 3) == 0) a_valid = 1'b0;
      end
      @(negedge clk);
      if (fin) break;
    end
    m_ready = 1'b0;
    exp_err = (w > TO_TB - 1);
    e_rd = exp_err ? 32'hFFFF_FFFF : mdata;
    if (win_b) mdl_rd_b = e_rd; else mdl_rd_a = e_rd;
    chk("done_mvalid", m_valid, 1'b0);
    chk("done_owner", owner, win_b ? 2'b10 : 2'b01);
    chk("done_a_ready", a_ready, !win_b);
    chk("done_b_ready", b_ready, win_b);
    chk("done_a_error", a_error, !win_b && exp_err);
    chk("done_b_error", b_error, win_b && exp_err);
    chk("done_a_rdata", a_rdata, mdl_rd_a);
    chk("done_b_rdata", b_rdata, mdl_rd_b);
    // some requesters stay asserted through DONE, which must be ignored there
    if ($urandom_range(0, 1) == 0) a_valid = 1'b0;
    if ($urandom_range(0, 1) == 0) b_valid = 1'b0;
    @(negedge clk);
    chk("post_error", {a_error, b_error}, 2'b00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    bit          va, vb;
    mem_resetn = 1'b0;
    a_valid = 0; b_valid = 0; m_ready = 0; m_rdata = '0;
    a_wstrb = '0; a_addr = '0; a_wdata = '0;
    b_wstrb = '0; b_addr = '0; b_wdata = '0;
    f_a_valid = 0; f_b_valid = 0; f_m_ready = 0; f_a_addr = 32'hA0A0_0040;
    mdl_last_b = 1'b1; mdl_rd_a = '0; mdl_rd_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_mvalid", m_valid, 1'b0);
    chk("rst_owner", owner, 2'b00);
    chk("rst_mbus", {m_wstrb, m_addr, m_wdata}, '0);
    chk("rst_ready_err", {a_ready, b_ready, a_error, b_error}, 4'h0);
    chk("rst_a_rdata", a_rdata, 32'h0);
    chk("rst_b_rdata", b_rdata, 32'h0);
    mem_resetn = 1'b1;

    // directed: A read with 2 waits, B byte write, four ties, timeout edges
    run_txn(1, 0, 4'h0, 32'h10, 32'h0, 4'h0, 32'h0, 32'h0, 2, 32'hDEAD_BEEF);
    run_txn(0, 1, 4'h0, 32'h0, 32'h0, 4'b0100, 32'h20, 32'h00AB_0000, 1, 32'h5555_AAAA);
    for (int t = 0; t < 4; t++)
      run_txn(1, 1, 4'h0, 32'h100 + t, 32'h0, 4'hF, 32'h200 + t, 32'h7, 0, 32'h1000 + t);
    run_txn(1, 0, 4'h0, 32'h40, 32'h0, 4'h0, 32'h0, 32'h0, 40, 32'h0BAD_0BAD);
    run_txn(1, 0, 4'h0, 32'h44, 32'h0, 4'h0, 32'h0, 32'h0, 3, 32'hC0FF_EE00);
    run_txn(1, 0, 4'h0, 32'h48, 32'h0, 4'h0, 32'h0, 32'h0, TO_TB - 1, 32'h600D_DA7A);
    run_txn(0, 1, 4'h0, 32'h0, 32'h0, 4'h3, 32'h4C, 32'h9, TO_TB, 32'h1111_2222);

    for (int i = 0; i < 80; i++) begin
      va = 1'($urandom);
      vb = 1'($urandom);
      if (!va && !vb) va = 1'b1;
      run_txn(va, vb, 4'($urandom), $urandom, $urandom, 4'($urandom), $urandom, $urandom,
              $urandom_range(0, 10), $urandom);
    end

    // reset in the middle of a transfer
    a_valid = 1; b_valid = 1;
    @(negedge clk);
    chk("mid_busy_mvalid", m_valid, 1'b1);
    mem_resetn = 1'b0;
    #1;
    chk("async_rst_mvalid", m_valid, 1'b0);
    chk("async_rst_owner", owner, 2'b00);
    chk("async_rst_ready", {a_ready, b_ready}, 2'b00);
    a_valid = 0; b_valid = 0;
    mdl_last_b = 1'b1; mdl_rd_a = '0; mdl_rd_b = '0;
    @(negedge clk);
    chk("rst_hold_ready", {a_ready, b_ready}, 2'b00);
    mem_resetn = 1'b1;
    run_txn(1, 1, 4'h0, 32'h300, 32'h0, 4'h0, 32'h304, 32'h0, 1, 32'hFEED_F00D);

    // fixed priority: A keeps winning while both are held
    f_a_valid = 1; f_b_valid = 1;
    for (int t = 0; t < 4; t++) begin
      for (int n = 0; n < 6 && f_m_valid !== 1'b1; n++) @(negedge clk);
      chk("fx_grant_valid", f_m_valid, 1'b1);
      chk("fx_owner", f_owner, 2'b01);
      chk("fx_addr", f_m_addr, 32'hA0A0_0040);
      f_m_ready = 1;
      @(negedge clk);
      f_m_ready = 0;
      chk("fx_a_ready", f_a_ready, 1'b1);
      chk("fx_b_ready", f_b_ready, 1'b0);
      chk("fx_a_rdata", f_a_rdata, 32'h1234_5678);
    end
    f_a_valid = 0; f_b_valid = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_nubus_mem_arbiter
`default_nettype wire
